// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART tx scheduler
// Holds the scheduler state encoding, the byte and word widths, and the byte selector helper.
package uart_sched_pkg;

    localparam int NB_BYTE = 8;
    localparam int NB_WORD = 16;

    // Byte-select codes for the word register mux.
    localparam logic BYTE_SEL_HI = 1'b1;
    localparam logic BYTE_SEL_LO = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_WAIT_LO = 3'd5
    } state_e;

    function automatic logic [NB_BYTE-1:0] byte_of(input logic [NB_WORD-1:0] word,
                                                   input logic              sel);
        return (sel == BYTE_SEL_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - byte handshake between scheduler and tx serializer
// Signals:
//   tx_start : 1-cycle pulse from the scheduler, tx_data valid, start a byte
//   tx_data  : byte to send, stable from start until done
//   tx_done  : 1-cycle pulse from the serializer, byte finished
// Modports: master = scheduler side, slave = serializer side.
interface uart_tx_if;
    import uart_sched_pkg::*;

    logic               tx_start;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_done;

    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - round-robin arbiter with registered priority pointer
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset
//   i_req            : per-requester request levels
//   i_advance        : a grant is being taken this cycle; move pointer past the winner
//   o_grant_onehot   : combinational winner, one-hot (zero when no request)
//   o_grant_id       : combinational winner index
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int NB_ID   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant_onehot,
    output logic [NB_ID-1:0]   o_grant_id
);

    // ptr_q is the index with highest priority: one past the last grant.
    logic [NB_ID-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        o_grant_onehot = '0;
        o_grant_id     = '0;
        found          = 1'b0;
        idx            = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && i_req[idx]) begin
                found               = 1'b1;
                o_grant_id          = NB_ID'(idx);
                o_grant_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && found) begin
            if (o_grant_id == NB_ID'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = o_grant_id + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter between NUM_REQ word producers
// Each granted 16-bit word goes out as two bytes, MSB first, via the tx start/done handshake.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-low reset
//   i_req, i_data   : per-requester word valid and flat word bus (requester k at [k*NB_DATA +: NB_DATA])
//   o_ack           : one-hot 1-cycle pulse, word of that requester latched
//   tx              : byte handshake to the serializer (master side)
//   o_busy          : any state other than IDLE
//   o_grant_id      : index of current/last granted requester
//   o_timeout       : sticky watchdog flag, cleared by i_clr_timeout
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int NB_DATA     = NB_WORD,
    parameter  int TIMEOUT_CYC = 65535,
    localparam int NB_ID       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*NB_DATA-1:0] i_data,
    output logic [NUM_REQ-1:0]         o_ack,
    uart_tx_if.master                  tx,
    output logic                       o_busy,
    output logic [NB_ID-1:0]           o_grant_id,
    output logic                       o_timeout,
    input  logic                       i_clr_timeout
);

    localparam int                 NB_WDOG    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [NB_WDOG-1:0] WDOG_LIMIT = NB_WDOG'(TIMEOUT_CYC - 1);
    localparam logic [NB_WDOG-1:0] WDOG_MAX   = '1;

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
    logic [NB_ID-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [NB_WDOG-1:0]   wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    logic                 arb_advance;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [NB_ID-1:0]     arb_id;
    logic [NB_DATA-1:0]   granted_word;
    logic                 wait_state;
    logic                 wdog_expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_advance      (arb_advance),
        .o_grant_onehot (arb_onehot),
        .o_grant_id     (arb_id)
    );

    // Word select uses the registered grant, so i_req never reaches o_ack combinationally.
    assign granted_word = i_data[int'(grant_id_q) * NB_DATA +: NB_DATA];

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        grant_oh_d   = grant_oh_q;
        wdog_d       = wdog_q;
        arb_advance  = 1'b0;
        wait_state   = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
        // A done arriving on the limit cycle still completes the byte.
        wdog_expired = wait_state && !tx.tx_done && (wdog_q >= WDOG_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    grant_id_d  = arb_id;
                    grant_oh_d  = arb_onehot;
                    arb_advance = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                word_d    = granted_word;
                tx_data_d = byte_of(granted_word, BYTE_SEL_HI);
                state_d   = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                wdog_d  = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx.tx_done) begin
                    tx_data_d = byte_of(word_q, BYTE_SEL_LO);
                    state_d   = ST_SEND_LO;
                end else if (wdog_expired) begin
                    state_d = ST_IDLE;
                end else if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_SEND_LO: begin
                wdog_d  = '0;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (tx.tx_done || wdog_expired) begin
                    state_d = ST_IDLE;
                end else if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry beats a simultaneous clear so an error is never lost.
        timeout_d = timeout_q;
        if (i_clr_timeout) begin
            timeout_d = 1'b0;
        end
        if (wdog_expired) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_ack       = (state_q == ST_GRANT) ? grant_oh_q : '0;
    assign tx.tx_start = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
    assign tx.tx_data  = tx_data_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_grant_id  = grant_id_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  gid;
    logic        timeout;
    logic        clr;

    int checks = 0;
    int errors = 0;

    uart_tx_if tx_if ();

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ     (4),
        .NB_DATA     (16),
        .TIMEOUT_CYC (32)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_req         (req),
        .i_data        (data),
        .o_ack         (ack),
        .tx            (tx_if.master),
        .o_busy        (busy),
        .o_grant_id    (gid),
        .o_timeout     (timeout),
        .i_clr_timeout (clr)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        data = '0;
        clr = 1'b0;
        tx_if.tx_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_if.tx_start) begin
                seen = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic pulse_done(input int gap);
        repeat (gap) step();
        tx_if.tx_done = 1'b1;
        step();
        tx_if.tx_done = 1'b0;
    endtask

    task automatic serve_word(input int gap, output bit ok);
        bit s1, s2;
        step();
        wait_start(s1);
        pulse_done(gap);
        wait_start(s2);
        pulse_done(gap);
        ok = s1 && s2;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++;
        if (tx_if.tx_start !== 1'b0 || tx_if.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx: got start=%b data=%h expected 0/00", tx_if.tx_start, tx_if.tx_data);
        end
        checks++;
        if (busy !== 1'b0 || gid !== 2'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL reset_status: got busy=%b gid=%0d timeout=%b expected 0/0/0", busy, gid, timeout);
        end
    endtask

    task automatic test_single();
        bit seen;
        data[15:0] = 16'hA55A;
        req = 4'b0001;
        step();
        checks++;
        if (ack !== 4'b0001 || tx_if.tx_start !== 1'b0) begin
            errors++; $display("FAIL single_ack: got ack=%b start=%b expected 0001/0", ack, tx_if.tx_start);
        end
        req = 4'b0000;
        step();
        checks++;
        if (tx_if.tx_start !== 1'b1 || tx_if.tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_hi: got start=%b data=%h expected 1/a5", tx_if.tx_start, tx_if.tx_data);
        end
        pulse_done(10);
        wait_start(seen);
        checks++;
        if (!seen || tx_if.tx_data !== 8'h5A) begin
            errors++; $display("FAIL single_lo: got seen=%0d data=%h expected 1/5a", seen, tx_if.tx_data);
        end
        pulse_done(10);
        checks++;
        if (busy !== 1'b0 || tx_if.tx_data !== 8'h5A) begin
            errors++; $display("FAIL single_end: got busy=%b data=%h expected 0/5a", busy, tx_if.tx_data);
        end
    endtask

    task automatic test_contention();
        bit seen;
        bit got_ack;
        int exp_id;
        logic [15:0] exp_word;
        do_reset();
        data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            exp_id = w % 4;
            exp_word = 16'h1111 * 16'(exp_id + 1);
            got_ack = 1'b0;
            for (int c = 0; c < 10; c++) begin
                checks++;
                if ($countones(ack) > 1) begin
                    errors++; $display("FAIL contention_onehot: got ack=%b expected at most one bit", ack);
                end
                if (ack != 4'b0000) begin
                    got_ack = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (!got_ack || ack !== (4'b0001 << exp_id) || gid !== 2'(exp_id)) begin
                errors++; $display("FAIL contention_grant%0d: got ack=%b gid=%0d expected id %0d", w, ack, gid, exp_id);
            end
            step();
            wait_start(seen);
            checks++;
            if (!seen || tx_if.tx_data !== exp_word[15:8]) begin
                errors++; $display("FAIL contention_hi%0d: got %h expected %h", w, tx_if.tx_data, exp_word[15:8]);
            end
            pulse_done(2);
            wait_start(seen);
            checks++;
            if (!seen || tx_if.tx_data !== exp_word[7:0]) begin
                errors++; $display("FAIL contention_lo%0d: got %h expected %h", w, tx_if.tx_data, exp_word[7:0]);
            end
            pulse_done(2);
            if (w == 0) begin
                checks++;
                if (busy !== 1'b0 || ack !== 4'b0000) begin
                    errors++; $display("FAIL back_to_back_idle: got busy=%b ack=%b expected 0/0000", busy, ack);
                end
                step();
                checks++;
                if (ack !== 4'b0010) begin
                    errors++; $display("FAIL back_to_back_ack: got %b expected 0010", ack);
                end
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_rr_fairness();
        bit ok;
        do_reset();
        data[47:32] = 16'hC0DE;
        data[15:0]  = 16'h0F0F;
        req = 4'b0100;
        step();
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL rr_first: got %b expected 0100", ack); end
        req = 4'b0000;
        serve_word(1, ok);
        req = 4'b0101;
        step();
        checks++;
        if (!ok || ack !== 4'b0001 || gid !== 2'd0) begin
            errors++; $display("FAIL rr_wrap: got ack=%b gid=%0d served=%0d expected 0001/0/1", ack, gid, ok);
        end
        req = 4'b0100;
        serve_word(1, ok);
        step();
        checks++;
        if (!ok || ack !== 4'b0100 || gid !== 2'd2) begin
            errors++; $display("FAIL rr_second: got ack=%b gid=%0d served=%0d expected 0100/2/1", ack, gid, ok);
        end
        req = 4'b0000;
        serve_word(1, ok);
    endtask

    task automatic test_timeout();
        bit saw;
        do_reset();
        data[15:0] = 16'hBEEF;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (tx_if.tx_start !== 1'b1 || tx_if.tx_data !== 8'hBE) begin
            errors++; $display("FAIL timeout_hi: got start=%b data=%h expected 1/be", tx_if.tx_start, tx_if.tx_data);
        end
        repeat (32) step();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got timeout=%b busy=%b expected 0/1", timeout, busy);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_fire: got timeout=%b busy=%b expected 1/0", timeout, busy);
        end
        saw = 1'b0;
        repeat (6) begin
            step();
            if (tx_if.tx_start) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_no_lo: got start_seen=%0d timeout=%b expected 0/1", saw, timeout);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        clr = 1'b1;
        repeat (33) step();
        checks++;
        if (timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_beats_clear: got %b expected 1", timeout);
        end
        clr = 1'b0;
    endtask

    task automatic test_stray_done();
        bit seen;
        do_reset();
        tx_if.tx_done = 1'b1;
        step();
        tx_if.tx_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_if.tx_start !== 1'b0) begin
            errors++; $display("FAIL stray_idle: got busy=%b start=%b expected 0/0", busy, tx_if.tx_start);
        end
        data[15:0] = 16'h1234;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        tx_if.tx_done = 1'b1;
        step();
        tx_if.tx_done = 1'b0;
        step();
        checks++;
        if (tx_if.tx_start !== 1'b0 || busy !== 1'b1 || tx_if.tx_data !== 8'h12) begin
            errors++; $display("FAIL stray_send_hi: got start=%b busy=%b data=%h expected 0/1/12", tx_if.tx_start, busy, tx_if.tx_data);
        end
        pulse_done(3);
        wait_start(seen);
        checks++;
        if (!seen || tx_if.tx_data !== 8'h34) begin
            errors++; $display("FAIL stray_lo: got seen=%0d data=%h expected 1/34", seen, tx_if.tx_data);
        end
        pulse_done(3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stray_end: got busy=%b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        bit seen;
        do_reset();
        data[31:16] = 16'hC3D4;
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        wait_start(seen);
        pulse_done(2);
        wait_start(seen);
        step();
        checks++;
        if (!seen || busy !== 1'b1 || gid !== 2'd1 || tx_if.tx_data !== 8'hD4) begin
            errors++; $display("FAIL areset_pre: got seen=%0d busy=%b gid=%0d data=%h expected 1/1/1/d4", seen, busy, gid, tx_if.tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0000 || tx_if.tx_start !== 1'b0 || tx_if.tx_data !== 8'h00 ||
            busy !== 1'b0 || gid !== 2'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL areset_outputs: got ack=%b start=%b data=%h busy=%b gid=%0d timeout=%b expected all 0",
                               ack, tx_if.tx_start, tx_if.tx_data, busy, gid, timeout);
        end
        step();
        rst_n = 1'b1;
        data[15:0] = 16'h7788;
        req = 4'b0001;
        step();
        checks++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL areset_next_ack: got %b expected 0001", ack); end
        req = 4'b0000;
        step();
        checks++;
        if (tx_if.tx_start !== 1'b1 || tx_if.tx_data !== 8'h77) begin
            errors++; $display("FAIL areset_next_hi: got start=%b data=%h expected 1/77", tx_if.tx_start, tx_if.tx_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        data = '0;
        clr = 1'b0;
        tx_if.tx_done = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_rr_fairness();
        test_timeout();
        test_stray_done();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 500000 time units");
        $fatal(1, "bench time limit expired");
    end

endmodule
